pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Drives per-stage stall
//  enables into pc/if_id/id_ex/ex_mem/mem_wb, sequences multi-cycle EX ops
//  (madd/msub/div) with a countdown FSM, and issues exception flushes with a redirect PC.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  CNT_W   5   width of mc_len and the internal multi-cycle countdown
//  PERF_W  32  width of stall_cycles performance counter
// PORTS
//  clk           in   1       core clock, all state on rising edge
//  rst           in   1       asynchronous, active-high reset
//  stallreq_id   in   1       ID stage stall request (load-use etc.)
//  stallreq_ex   in   1       EX stage stall request
//  mc_start      in   1       1-cycle pulse: multi-cycle op entered EX this cycle
//  mc_len        in   CNT_W   total EX occupancy of that op, in cycles
//  flush_req     in   1       MEM stage exception; flush whole pipe
//  excp_pc       in   32      redirect target for flush
//  cnt_clr       in   1       synchronous clear of stall_cycles
//  stall         out  6       [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb; 1=hold
//  flush         out  1       clear all pipeline registers this cycle
//  new_pc        out  32      valid when flush=1, else 0
//  mc_last       out  1       final EX cycle of multi-cycle op (pipe advances)
//  ctrl_state    out  2       00 RUN, 01 MC_BUSY, 10 FLUSH
//  stall_cycles  out  PERF_W  count of cycles with stall[0]=1, saturating
// BEHAVIOUR
//  - Reset: state=RUN, countdown=0, stall_cycles=0; while rst=1 all outputs 0.
//  - stall/flush/new_pc/mc_last are combinational from state+inputs (same cycle).
//  - Priority: rst > flush_req > multi-cycle sequencing > stall requests.
//  - Stall codes: EXS=6'b001111, IDS=6'b000111, none=6'b000000. mem_wb never
//    stalled by EX-side stalls; ex_mem inserts bubble.
//  - RUN: flush_req -> flush=1, new_pc=excp_pc, stall=0, next FLUSH.
//    else mc_start & mc_len>=2 -> stall=EXS, cnt<=mc_len-1, next MC_BUSY.
//    else mc_start & mc_len<=1 -> mc_last=1, no stall from op, stay RUN.
//    stall = EXS if stallreq_ex, else IDS if stallreq_id, else 0 (ORed with op stall).
//  - MC_BUSY: mc_start ignored. flush_req -> flush as RUN, cnt<=0, next FLUSH.
//    cnt>1: stall=EXS, cnt<=cnt-1. cnt==1: mc_last=1, op stall released
//    (stallreq_* still applied), next RUN. Total op stall = mc_len-1 cycles.
//  - FLUSH: one guard cycle; flush=0, stall=0, flush_req/mc_start/stallreq_* masked
//    (squashed instrs); next RUN.
//  - stall_cycles: +1 each cycle stall[0]=1; holds at 2^PERF_W-1; cnt_clr -> 0
//    next edge, clear wins over simultaneous increment.
//  - Reset mid-MC_BUSY: outputs 0 immediately (async), countdown discarded.
//  - ctrl_state encoding 11 unreachable; if entered, return to RUN next edge.
// TESTING
//  1 mc_start, mc_len=4 at cyc 10 -> stall=6'h0F cyc 10-12, cyc 13 stall=0,
//    mc_last=1, state RUN at cyc 14; stall_cycles=3.
//  2 stallreq_id only -> stall=6'h07; stallreq_id+stallreq_ex -> 6'h0F; none -> 0.
//  3 flush_req, excp_pc=32'h0000_0020 in MC_BUSY cnt=3 -> same cycle flush=1,
//    new_pc=0x20, stall=0; next cycle state FLUSH, flush=0 with flush_req held; then RUN.
//  4 mc_start, mc_len=1 and mc_len=0 -> mc_last=1 same cycle, stall=0, state stays RUN.
//  5 rst pulse async mid MC_BUSY cnt=5 -> all outputs 0 before next edge; after
//    release state RUN, stall_cycles=0, no residual stall.
//  6 PERF_W=4, stallreq_id held 20 cycles -> stall_cycles stops at 15; cnt_clr with
//    stall active -> 0 next edge, then counts 1,2,...

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage core.
// Generates per-stage hold enables, sequences multi-cycle EX operations with a
// countdown, issues exception flushes with a redirect PC and keeps a saturating
// count of cycles in which the PC was held.
module pipe_ctrl #(
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_len,
    input  logic              flush_req,
    input  logic [31:0]       excp_pc,
    input  logic              cnt_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_last,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] stall_cycles
);

    // EX-side stalls hold pc..ex_mem and leave mem_wb running (bubble into MEM);
    // ID-side stalls hold pc..id_ex only.
    localparam logic [5:0] STALL_EXS  = 6'b001111;
    localparam logic [5:0] STALL_IDS  = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_BUSY = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]       req_stall;

    assign ctrl_state = state;

    // Next-state and same-cycle outputs; everything forced low while rst is high
    always_comb begin
        stall     = STALL_NONE;
        flush     = 1'b0;
        new_pc    = '0;
        mc_last   = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        req_stall = stallreq_ex ? STALL_EXS : (stallreq_id ? STALL_IDS : STALL_NONE);

        case (state)
            RUN: begin
                if (flush_req) begin
                    flush     = 1'b1;
                    new_pc    = excp_pc;
                    state_nxt = FLUSH;
                end else begin
                    stall = req_stall;
                    if (mc_start) begin
                        if (mc_len >= CNT_W'(2)) begin
                            stall     = STALL_EXS | req_stall;
                            cnt_nxt   = mc_len - CNT_W'(1);
                            state_nxt = MC_BUSY;
                        end else begin
                            mc_last = 1'b1;
                        end
                    end
                end
            end
            MC_BUSY: begin
                if (flush_req) begin
                    flush     = 1'b1;
                    new_pc    = excp_pc;
                    cnt_nxt   = '0;
                    state_nxt = FLUSH;
                end else if (cnt > CNT_W'(1)) begin
                    stall   = STALL_EXS | req_stall;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    // Final EX cycle: op stall released, external requests still honoured
                    stall     = req_stall;
                    mc_last   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            stall   = STALL_NONE;
            flush   = 1'b0;
            new_pc  = '0;
            mc_last = 1'b0;
        end
    end

    // Controller state and multi-cycle countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of PC-hold cycles; clear takes precedence over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (stall[0] && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand-written multi-cycle sequences
// for pipe_ctrl. A second instance with a 4-bit counter exercises saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, mc_start, flush_req, cnt_clr;
    logic [4:0]  mc_len;
    logic [31:0] excp_pc;

    logic [5:0]  stall, stall4;
    logic        flush, flush4, mc_last, mc_last4;
    logic [31:0] new_pc, new_pc4;
    logic [1:0]  ctrl_state, ctrl_state4;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(5), .PERF_W(32)) u_dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .excp_pc(excp_pc),
        .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_last(mc_last), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.CNT_W(5), .PERF_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .excp_pc(excp_pc),
        .cnt_clr(cnt_clr), .stall(stall4), .flush(flush4), .new_pc(new_pc4),
        .mc_last(mc_last4), .ctrl_state(ctrl_state4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        logic        id;
        logic        ex;
        logic        ms;
        logic [4:0]  ml;
        logic        fr;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_last;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic id, input logic ex, input logic ms, input logic [4:0] ml,
                         input logic fr, input logic [31:0] pc, input logic clr);
        stallreq_id = id;
        stallreq_ex = ex;
        mc_start    = ms;
        mc_len      = ml;
        flush_req   = fr;
        excp_pc     = pc;
        cnt_clr     = clr;
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] e_stall, input logic e_flush,
                              input logic [31:0] e_pc, input logic e_last, input logic [1:0] e_state);
        check({tag, ".stall"},      32'(stall),      32'(e_stall));
        check({tag, ".flush"},      32'(flush),      32'(e_flush));
        check({tag, ".new_pc"},     new_pc,          e_pc);
        check({tag, ".mc_last"},    32'(mc_last),    32'(e_last));
        check({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(e_state));
    endtask

    int model_cnt;

    initial begin
        //          id    ex    ms    ml     fr    pc            stall  fl    npc           last  state
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        6'h07, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        6'h0F, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        6'h0F, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        1'b1, 2'b00};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        1'b1, 2'b00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 32'h0,        6'h07, 1'b0, 32'h0,        1'b1, 2'b00};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h40,       6'h00, 1'b1, 32'h40,       1'b0, 2'b00};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 32'h44,       6'h00, 1'b0, 32'h0,        1'b0, 2'b10};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 32'h0,        6'h0F, 1'b0, 32'h0,        1'b0, 2'b00};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        6'h07, 1'b0, 32'h0,        1'b1, 2'b01};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'hDEAD_BEEF, 6'h00, 1'b0, 32'h0,       1'b0, 2'b00};

        // Reset state: everything low while rst is held
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 32'h1234, 1'b0);
        #2;
        check_outs("reset", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);
        check("reset.stall_cycles", stall_cycles, 32'h0);
        cyc();
        cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;

        // Vector table, one vector per cycle
        model_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].id, tbl[i].ex, tbl[i].ms, tbl[i].ml, tbl[i].fr, tbl[i].pc, 1'b0);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush,
                       tbl[i].e_pc, tbl[i].e_last, tbl[i].e_state);
            if (tbl[i].e_stall[0]) model_cnt++;
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check("vec.stall_cycles", stall_cycles, 32'(model_cnt));

        // mc_len=4: three held cycles, then the releasing last cycle
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0, 1'b0);
        #1;
        check_outs("mc4.c0", 6'h0F, 1'b0, 32'h0, 1'b0, 2'b00);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0, 1'b0);
        #1;
        check_outs("mc4.c1", 6'h0F, 1'b0, 32'h0, 1'b0, 2'b01);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outs("mc4.c2", 6'h0F, 1'b0, 32'h0, 1'b0, 2'b01);
        cyc();
        #1;
        check_outs("mc4.c3", 6'h00, 1'b0, 32'h0, 1'b1, 2'b01);
        cyc();
        #1;
        check_outs("mc4.c4", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);
        check("mc4.stall_cycles", stall_cycles, 32'd3);

        // Flush arriving mid multi-cycle op (cnt=3), held across the guard cycle
        drive(1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0020, 1'b0);
        #1;
        check_outs("fl.c0", 6'h00, 1'b1, 32'h20, 1'b0, 2'b01);
        cyc();
        #1;
        check_outs("fl.c1", 6'h00, 1'b0, 32'h0, 1'b0, 2'b10);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outs("fl.c2", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);

        // Async reset mid multi-cycle op (cnt=5)
        drive(1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 32'h0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outs("rst.pre", 6'h0F, 1'b0, 32'h0, 1'b0, 2'b01);
        #1;
        rst = 1'b1;
        flush_req = 1'b1;
        excp_pc = 32'h88;
        #1;
        check_outs("rst.mid", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);
        check("rst.mid.stall_cycles", stall_cycles, 32'h0);
        cyc();
        #2;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check_outs("rst.post0", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);
        cyc();
        #1;
        check_outs("rst.post1", 6'h00, 1'b0, 32'h0, 1'b0, 2'b00);
        check("rst.post1.stall_cycles", stall_cycles, 32'h0);

        // Saturation of the 4-bit counter, then clear with stall active
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) cyc();
        #1;
        check("sat.cnt4", 32'(stall_cycles4), 32'd15);
        check("sat.cnt32", stall_cycles, 32'd20);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        #1;
        check("clr.cnt4", 32'(stall_cycles4), 32'd0);
        check("clr.cnt32", stall_cycles, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            #1;
            check($sformatf("recount%0d", i), 32'(stall_cycles4), 32'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
